ram_arbiter: RTL

Two-port arbiter and access sequencer for the single-port synchronous `ram` block (8-bit data, 8-bit address, `enab`/`rw` control, registered `data_out`). It shares the RAM between requester 0 (instruction fetch) and requester 1 (operand load/store) using round-robin priority. It latches each request, drives the RAM control lines for exactly one enabled cycle, captures read data and returns a one-cycle done pulse.

---
 rtl/ram_arbiter_pkg.sv | 16 +
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter_rr_arb2.sv | 12 +
 rtl/ram_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM encoding, access
// direction codes and default bus widths.
package ram_arb_pkg;

    localparam int D_WIDTH = 8;
    localparam int A_WIDTH = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side handshake and RAM-side control bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ram_arbiter_if #(
    parameter int d_width = 8,
    parameter int a_width = 8
);
    logic               req0, rw0, req1, rw1;
    logic [a_width-1:0] addr0, addr1;
    logic [d_width-1:0] wdata0, wdata1;
    logic               gnt0, gnt1, done0, done1, busy;
    logic [d_width-1:0] rdata;
    logic               ram_enab, ram_rw;
    logic [a_width-1:0] ram_addr;
    logic [d_width-1:0] ram_din, ram_dout;

    modport slave (
        input  req0, rw0, addr0, wdata0,
        input  req1, rw1, addr1, wdata1,
        input  ram_dout,
        output gnt0, gnt1, done0, done1, busy, rdata,
        output ram_enab, ram_rw, ram_addr, ram_din
    );

    modport master (
        output req0, rw0, addr0, wdata0,
        output req1, rw1, addr1, wdata1,
        output ram_dout,
        input  gnt0, gnt1, done0, done1, busy, rdata,
        input  ram_enab, ram_rw, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// whichever side the priority bit currently favours.
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    output logic o_sel,
    output logic o_valid
);
    assign o_valid = i_req0 | i_req1;
    assign o_sel   = (i_req0 & i_req1) ? i_prio : i_req1;
endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters: latches the
// winning request, issues one enabled RAM cycle, captures read data, pulses done.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int d_width = D_WIDTH,
    parameter int a_width = A_WIDTH
) (
    input  logic           clk,
    input  logic           clr,
    ram_arbiter_if.slave   bus
);

    logic [1:0]         r_state;
    logic               r_owner;
    logic               r_rw;
    logic               r_prio;
    logic [a_width-1:0] r_addr;
    logic [d_width-1:0] r_wdata;
    logic [d_width-1:0] r_rdata;
    logic [1:0]         r_gnt;
    logic [1:0]         r_done;
    logic               r_busy;
    logic               r_enab;
    logic               r_ram_rw;

    logic               w_sel;
    logic               w_valid;
    logic               w_rw;
    logic [a_width-1:0] w_addr;
    logic [d_width-1:0] w_wdata;

    rr_arb2 u_rr (
        .i_req0  (bus.req0),
        .i_req1  (bus.req1),
        .i_prio  (r_prio),
        .o_sel   (w_sel),
        .o_valid (w_valid)
    );

    assign w_rw    = w_sel ? bus.rw1    : bus.rw0;
    assign w_addr  = w_sel ? bus.addr1  : bus.addr0;
    assign w_wdata = w_sel ? bus.wdata1 : bus.wdata0;

    // All RAM-facing controls are flops so the RAM never sees decode glitches;
    // addr/din simply keep the last latched request between accesses.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_rw     <= RW_READ;
            r_prio   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_busy   <= 1'b0;
            r_enab   <= 1'b0;
            r_ram_rw <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner  <= w_sel;
                        r_rw     <= w_rw;
                        r_addr   <= w_addr;
                        r_wdata  <= w_wdata;
                        r_gnt    <= w_sel ? 2'b10 : 2'b01;
                        r_busy   <= 1'b1;
                        r_enab   <= 1'b1;
                        r_ram_rw <= w_rw;
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_enab   <= 1'b0;
                    r_ram_rw <= 1'b0;
                    if (r_rw == RW_WRITE) begin
                        r_done  <= r_gnt;
                        r_state <= ST_RESP;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // RAM registered memory[addr] at the end of ACCESS.
                    r_rdata <= bus.ram_dout;
                    r_done  <= r_gnt;
                    r_state <= ST_RESP;
                end
                default: begin
                    r_done  <= 2'b00;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_prio  <= ~r_owner;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = r_gnt[0];
    assign bus.gnt1     = r_gnt[1];
    assign bus.done0    = r_done[0];
    assign bus.done1    = r_done[1];
    assign bus.busy     = r_busy;
    assign bus.rdata    = r_rdata;
    assign bus.ram_enab = r_enab;
    assign bus.ram_rw   = r_ram_rw;
    assign bus.ram_addr = r_addr;
    assign bus.ram_din  = r_wdata;

endmodule
